fetch: RTL and testbench

- Instruction-fetch (A) stage. It sits directly upstream of the decode (B) stage.
- Owns the PC register and issues one request at a time to the instruction memory over a req/ack handshake.
- Produces the IF/ID pipeline register (InstrB, PCB, PCPlus4B) consumed by decode.
- Accepts branch/jump redirects (PCTargetA, PCSrcA) and hazard-unit stall/flush controls.

---
 rtl/fetch.sv | 69 ++++++
 tb/tb_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// fetch: instruction-fetch stage owning the PC, the imem req/ack handshake and the IF/ID register
module fetch #(
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PCTargetA,
   input  logic                  PCSrcA,
   input  logic                  StallA,
   input  logic                  FlushB,
   output logic                  IMemReq,
   output logic [DATA_WIDTH-1:0] IMemAddr,
   input  logic                  IMemAck,
   input  logic [31:0]           IMemData,
   output logic [31:0]           InstrB,
   output logic [DATA_WIDTH-1:0] PCB,
   output logic [DATA_WIDTH-1:0] PCPlus4B,
   output logic                  ValidB
);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD, KILL} state_t;
   state_t state, state_nx;
   logic [DATA_WIDTH-1:0] pc, pc_plus4;
   logic [31:0] hold_instr;
   logic ack_ok, load, capture;
   assign pc_plus4 = pc + DATA_WIDTH'(4);
   assign IMemAddr = pc;
   always_comb begin
      IMemReq = state == IDLE && !StallA && !PCSrcA && !rst;
      ack_ok = state == WAIT && IMemAck && !PCSrcA;
      load = !StallA && (ack_ok || (state == HOLD && !PCSrcA));
      capture = ack_ok && StallA;
      state_nx = state;
      case (state)
         IDLE: state_nx = IMemReq ? WAIT : IDLE;
         WAIT: state_nx = IMemAck ? (capture ? HOLD : IDLE) : (PCSrcA ? KILL : WAIT);
         HOLD: state_nx = (PCSrcA || !StallA) ? IDLE : HOLD;
         KILL: state_nx = IMemAck ? IDLE : KILL;
         default: state_nx = IDLE;
      endcase
   end
   // PC is unchanged while holding, so the held word's PC is still the live PC
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         hold_instr <= '0;
         InstrB <= NOP_INSTR;
         PCB <= '0;
         PCPlus4B <= '0;
         ValidB <= 1'b0;
      end else begin
         state <= state_nx;
         pc <= PCSrcA ? PCTargetA & ~DATA_WIDTH'(3) : load ? pc_plus4 : pc;
         if (capture) hold_instr <= IMemData;
         if (FlushB) begin
            InstrB <= NOP_INSTR;
            PCB <= '0;
            PCPlus4B <= '0;
            ValidB <= 1'b0;
         end else if (load) begin
            InstrB <= state == HOLD ? hold_instr : IMemData;
            PCB <= pc;
            PCPlus4B <= pc_plus4;
            ValidB <= 1'b1;
         end
      end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed stimulus with a transaction-level fetch model checked every cycle
module tb_fetch;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic clk = 1'b0;
   logic rst, PCSrcA, StallA, FlushB, IMemReq, IMemAck, ValidB;
   logic [31:0] PCTargetA, IMemAddr, IMemData, InstrB, PCB, PCPlus4B;
   int total = 0, bad = 0, lat = 1;

   fetch dut (
      .clk(clk), .rst(rst), .PCTargetA(PCTargetA), .PCSrcA(PCSrcA), .StallA(StallA),
      .FlushB(FlushB), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
      .IMemData(IMemData), .InstrB(InstrB), .PCB(PCB), .PCPlus4B(PCPlus4B), .ValidB(ValidB)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // memory: acks `lat` cycles after sampling a request, data = addr ^ K
   initial begin
      int cnt;
      logic r;
      logic [31:0] a, maddr;
      cnt = 0;
      maddr = '0;
      IMemAck = 1'b0;
      IMemData = '0;
      forever begin
         @(posedge clk);
         r = IMemReq;
         a = IMemAddr;
         #1;
         IMemAck = 1'b0;
         if (r) begin
            cnt = lat;
            maddr = a;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               IMemAck = 1'b1;
               IMemData = maddr ^ K;
            end
         end
      end
   end

   // model: one outstanding fetch (possibly doomed by a redirect), an optional held word
   logic [31:0] m_pc, m_hword, m_instr, m_pcb, m_pc4;
   logic m_out, m_dead, m_held, m_valid, e_req, got, dlv;
   assign e_req = !rst && !m_out && !m_held && !StallA && !PCSrcA;
   assign got = IMemAck && m_out;
   assign dlv = !PCSrcA && !StallA && ((got && !m_dead) || m_held);

   always @(posedge clk or posedge rst)
      if (rst) begin
         m_pc <= '0;
         m_out <= 1'b0;
         m_dead <= 1'b0;
         m_held <= 1'b0;
         m_hword <= '0;
         m_instr <= 32'h0000_0013;
         m_pcb <= '0;
         m_pc4 <= '0;
         m_valid <= 1'b0;
      end else begin
         m_out <= e_req || (m_out && !got);
         m_dead <= m_out && !got && (m_dead || PCSrcA);
         m_held <= !PCSrcA && (m_held ? StallA : got && !m_dead && StallA);
         if (got && !m_held) m_hword <= IMemData;
         m_pc <= PCSrcA ? PCTargetA & ~32'd3 : dlv ? m_pc + 32'd4 : m_pc;
         if (FlushB) begin
            m_instr <= 32'h0000_0013;
            m_pcb <= '0;
            m_pc4 <= '0;
            m_valid <= 1'b0;
         end else if (dlv) begin
            m_instr <= m_held ? m_hword : IMemData;
            m_pcb <= m_pc;
            m_pc4 <= m_pc + 32'd4;
            m_valid <= 1'b1;
         end
      end

   always @(negedge clk) begin
      chk("req", IMemReq, e_req);
      chk("addr", IMemAddr, m_pc);
      chk("instr", InstrB, m_instr);
      chk("pcb", PCB, m_pcb);
      chk("pcplus4", PCPlus4B, m_pc4);
      chk("valid", ValidB, m_valid);
   end

   initial begin
      PCSrcA = 0; StallA = 0; FlushB = 0; PCTargetA = '0;
      rst = 0;
      #1 rst = 1;
      #2;
      chk("rst_instr", InstrB, 32'h0000_0013);
      chk("rst_valid", ValidB, 0);
      chk("rst_pcb", PCB, 0);
      chk("rst_req", IMemReq, 0);
      chk("rst_addr", IMemAddr, 0);
      repeat (2) @(posedge clk);
      #2 rst = 0;
      // sequential run: one fetch every two cycles
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("run_req", IMemReq, 1);
         chk("run_addr", IMemAddr, 32'(4 * k));
         if (k > 0) begin
            chk("run_instr", InstrB, 32'(4 * (k - 1)) ^ K);
            chk("run_pcb", PCB, 32'(4 * (k - 1)));
            chk("run_pc4", PCPlus4B, 32'(4 * k));
            chk("run_valid", ValidB, 1);
         end
         @(negedge clk);
      end
      // stall on the ack of 0xC, held over three edges
      #1 StallA = 1;
      repeat (2) begin
         @(negedge clk);
         chk("stall_instr", InstrB, 32'hA5A5_0008);
         chk("stall_req", IMemReq, 0);
      end
      @(posedge clk);
      #2 StallA = 0;
      @(negedge clk);
      chk("unstall_instr", InstrB, 32'hA5A5_0008);
      chk("unstall_req", IMemReq, 0);
      @(negedge clk);
      chk("hold_instr", InstrB, 32'hA5A5_000C);
      chk("hold_pcb", PCB, 32'h0000_000C);
      chk("hold_pc4", PCPlus4B, 32'h0000_0010);
      chk("hold_addr", IMemAddr, 32'h0000_0010);
      // redirect while waiting on 0x10, slow memory
      #1 lat = 3;
      @(posedge clk);
      #2 PCSrcA = 1; PCTargetA = 32'h0000_0103;
      @(posedge clk);
      #2 PCSrcA = 0;
      @(negedge clk);
      chk("kill_req", IMemReq, 0);
      chk("kill_addr", IMemAddr, 32'h0000_0100);
      @(negedge clk);
      chk("kill_ack_instr", InstrB, 32'hA5A5_000C);
      @(negedge clk);
      chk("redir_req", IMemReq, 1);
      chk("redir_addr", IMemAddr, 32'h0000_0100);
      chk("redir_instr", InstrB, 32'hA5A5_000C);
      // flush collides with the ack of 0x100
      #1 lat = 1;
      @(posedge clk);
      #2 FlushB = 1;
      @(posedge clk);
      #2 FlushB = 0;
      @(negedge clk);
      chk("flush_instr", InstrB, 32'h0000_0013);
      chk("flush_valid", ValidB, 0);
      chk("flush_pcb", PCB, 0);
      chk("flush_addr", IMemAddr, 32'h0000_0104);
      // redirect on the ack cycle of 0x104, to an unaligned target near the top
      @(posedge clk);
      #2 PCSrcA = 1; PCTargetA = 32'hFFFF_FFFE;
      @(posedge clk);
      #2 PCSrcA = 0;
      @(negedge clk);
      chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
      chk("drop_valid", ValidB, 0);
      @(negedge clk);
      @(negedge clk);
      chk("wrap_instr", InstrB, 32'h5A5A_FFFC);
      chk("wrap_pcb", PCB, 32'hFFFF_FFFC);
      chk("wrap_pc4", PCPlus4B, 0);
      chk("wrap_next", IMemAddr, 0);
      // async reset in the middle of a WAIT for 0x4
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_addr", IMemAddr, 32'h0000_0004);
      #1 lat = 3;
      @(posedge clk);
      #3 rst = 1; StallA = 1;
      #1;
      chk("arst_addr", IMemAddr, 0);
      chk("arst_valid", ValidB, 0);
      chk("arst_instr", InstrB, 32'h0000_0013);
      chk("arst_pc4", PCPlus4B, 0);
      chk("arst_req", IMemReq, 0);
      @(negedge clk);
      #2 rst = 0;
      @(negedge clk);
      chk("stale_valid", ValidB, 0);
      chk("stale_addr", IMemAddr, 0);
      @(posedge clk);
      #2 StallA = 0; lat = 1;
      @(negedge clk);
      chk("post_req", IMemReq, 1);
      chk("post_addr", IMemAddr, 0);
      repeat (4) @(negedge clk);
      chk("post_instr", InstrB, 32'hA5A5_0004);
      chk("post_pcb", PCB, 32'h0000_0004);
      chk("post_addr2", IMemAddr, 32'h0000_0008);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
